// File: rtl/pipeline5_pkg.sv
// Shared types for the pipeline5 writeback path: result-select encoding and
// the MEM->WB payload record carried through every writeback stage.
package pipeline5_pkg;

  // Payload field widths. The writeback pipe checks at elaboration that its
  // WORD_WIDTH / REG_ADDR_WIDTH parameters agree with these.
  localparam int WB_WORD_WIDTH     = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_ZERO = 2'b11
  } result_src_e;

  typedef struct packed {
    logic                         regwrite;
    result_src_e                  result_src;
    logic [WB_WORD_WIDTH-1:0]     alu_result;
    logic [WB_WORD_WIDTH-1:0]     read_data;
    logic [WB_WORD_WIDTH-1:0]     pc_plus4;
    logic [WB_REG_ADDR_WIDTH-1:0] rd;
  } wb_payload_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: picks ALU result, load data or link value from a
// payload record. Purely combinational so forwarding logic can reuse it.
module wb_result_mux
  import pipeline5_pkg::*;
(
  input  wb_payload_t              payload,
  output logic [WB_WORD_WIDTH-1:0] result
);

  // Decode result_src; the 11 encoding deliberately yields zero.
  always_comb begin
    result = '0;
    unique case (payload.result_src)
      RES_ALU:  result = payload.alu_result;
      RES_MEM:  result = payload.read_data;
      RES_PC4:  result = payload.pc_plus4;
      RES_ZERO: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_pipe.sv
// MEM->WB pipeline register with DEPTH stages, valid bits, stall/flush,
// result mux and retired-instruction counter.
// Build option: define WRITEBACK_PIPE_RETIRE_CNT_EN to build the retire
// counter; without it RetireCnt is tied to zero and no counter flops exist.
//
// Control semantics: every stage carries a valid bit; a stage whose valid is
// 0 is a bubble and never writes or retires. Per clock edge FlushW clears all
// valids (payload left as is), else StallW freezes every stage and ignores the
// M inputs, else the whole chain shifts one stage. Outputs always reflect the
// current last stage, so an entry sitting at W still writes in the flush
// cycle and repeats its write while stalled.
module writeback_pipe
  import pipeline5_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 1,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ValidM,
  input  logic                      RegWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [WORD_WIDTH-1:0]     ALUResultM,
  input  logic [WORD_WIDTH-1:0]     ReadDataM,
  input  logic [WORD_WIDTH-1:0]     PCPlus4M,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      StallW,
  input  logic                      FlushW,
  output logic                      ValidW,
  output logic                      RegWriteW,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic [WORD_WIDTH-1:0]     ResultW,
  output logic [CNT_WIDTH-1:0]      RetireCnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("writeback_pipe: DEPTH must be in 1..4");
  end
  if (WORD_WIDTH != WB_WORD_WIDTH || REG_ADDR_WIDTH != WB_REG_ADDR_WIDTH) begin : g_bad_width
    $error("writeback_pipe: widths must match pipeline5_pkg payload widths");
  end

  wb_payload_t      stage_in;
  wb_payload_t      stage_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  wb_payload_t      last;

  // Pack the M-stage inputs into a payload record for stage 0.
  always_comb begin
    stage_in            = '0;
    stage_in.regwrite   = RegWriteM;
    stage_in.result_src = result_src_e'(ResultSrcM);
    stage_in.alu_result = ALUResultM;
    stage_in.read_data  = ReadDataM;
    stage_in.pc_plus4   = PCPlus4M;
    stage_in.rd         = RdM;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    wb_payload_t d;
    logic        v_d;

    if (g == 0) begin : g_head
      assign d   = stage_in;
      assign v_d = ValidM;
    end else begin : g_tail
      assign d   = stage_q[g-1];
      assign v_d = valid_q[g-1];
    end

    // Stage register: flush beats stall beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[g] <= 1'b0;
        stage_q[g] <= '0;
      end else if (FlushW) begin
        valid_q[g] <= 1'b0;
      end else if (!StallW) begin
        valid_q[g] <= v_d;
        stage_q[g] <= d;
      end
    end
  end

  assign last      = stage_q[DEPTH-1];
  assign ValidW    = valid_q[DEPTH-1];
  assign RegWriteW = ValidW & last.regwrite & (last.rd != '0);
  assign RdW       = last.rd;

  wb_result_mux u_result_mux (
    .payload (last),
    .result  (ResultW)
  );

`ifdef WRITEBACK_PIPE_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_q;

  // Count an instruction when it leaves W: valid and not stalled. Flush does
  // not block it because the W entry still writes in the flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (ValidW && !StallW) begin
      retire_q <= retire_q + 1'b1;
    end
  end

  assign RetireCnt = retire_q;
`else
  assign RetireCnt = '0;
`endif

endmodule
